drca_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares a single DRCA adder instance between R requesters. It accepts one operand set per grant, drives the adder for one full clock cycle with its enable high, and captures the sum and carry. It then presents a tagged result on a valid/ready output port. It sits between the requesting units and the DRCA, and owns the DRCA `enable`, `A`, `B` and `Cin` inputs.

---
 rtl/drca_arbiter.sv | 116 +++++++++++
 tb/tb_drca_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/drca_arbiter.sv
// drca_arbiter: round-robin sequencer sharing one DRCA adder among R requesters.
// One operation per grant: IDLE (grant) -> EXEC (adder enabled) -> HOLD (result).
module drca_arbiter #(
    parameter int N = 8,
    parameter int R = 4,
    localparam int IDW = $clog2(R)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [R-1:0]   req,
    input  logic [R*N-1:0] a_in,
    input  logic [R*N-1:0] b_in,
    input  logic [R-1:0]   cin_in,
    output logic [R-1:0]   gnt,
    output logic           add_en,
    output logic [N-1:0]   add_a,
    output logic [N-1:0]   add_b,
    output logic           add_cin,
    input  logic [N-1:0]   add_s,
    input  logic           add_cout,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [IDW-1:0] res_id,
    output logic [N-1:0]   res_sum,
    output logic           res_cout,
    output logic           busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]     state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] id_q;
    logic [N-1:0]   op_a;
    logic [N-1:0]   op_b;
    logic           op_cin;

    logic [IDW-1:0] pick;
    logic [IDW-1:0] ptr_nxt;
    logic           found;
    logic           grant;
    int             j;

    // Search upward from ptr with wrap; first asserted request wins.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < R; k++) begin
            j = int'(ptr) + k;
            if (j >= R) j = j - R;
            if (!found && req[j]) begin
                found = 1'b1;
                pick  = IDW'(j);
            end
        end
        ptr_nxt = IDW'((int'(pick) + 1) % R);
    end

    assign grant = found && (state == IDLE) && !rst;

    always_comb begin
        gnt = '0;
        if (grant) gnt[pick] = 1'b1;
    end

    assign add_en  = (state == EXEC);
    assign add_a   = op_a;
    assign add_b   = op_b;
    assign add_cin = op_cin;
    assign res_id  = id_q;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            id_q      <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_cin    <= 1'b0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant) begin
                        op_a   <= a_in[int'(pick)*N +: N];
                        op_b   <= b_in[int'(pick)*N +: N];
                        op_cin <= cin_in[pick];
                        id_q   <= pick;
                        ptr    <= ptr_nxt;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    res_sum   <= add_s;
                    res_cout  <= add_cout;
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_drca_arbiter.sv
// tb_drca_arbiter: directed bench for drca_arbiter with a behavioural DRCA model.
// Inputs change 1ns after each rising edge; outputs are checked 1ns later.
module tb_drca_arbiter;

    localparam int N = 8;
    localparam int R = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [R-1:0]   req;
    logic [R*N-1:0] a_in;
    logic [R*N-1:0] b_in;
    logic [R-1:0]   cin_in;
    logic [R-1:0]   gnt;
    logic           add_en;
    logic [N-1:0]   add_a;
    logic [N-1:0]   add_b;
    logic           add_cin;
    logic [N-1:0]   add_s;
    logic           add_cout;
    logic           res_valid;
    logic           res_ready;
    logic [1:0]     res_id;
    logic [N-1:0]   res_sum;
    logic           res_cout;
    logic           busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] fa [4] = '{8'h01, 8'h10, 8'hF0, 8'h7F};
    logic [7:0] fb [4] = '{8'h02, 8'h20, 8'h20, 8'h80};
    logic       fc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] fs [4] = '{8'h03, 8'h31, 8'h10, 8'h00};
    logic       fo [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    always #5 clk = ~clk;

    // Behavioural DRCA: full N-bit add with carry out.
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};

    drca_arbiter #(.N(N), .R(R)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .cin_in    (cin_in),
        .gnt       (gnt),
        .add_en    (add_en),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_s     (add_s),
        .add_cout  (add_cout),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [7:0] a,
                          input logic [7:0] b, input logic c);
        a_in[i*N +: N] = a;
        b_in[i*N +: N] = b;
        cin_in[i]      = c;
    endtask

    initial begin
        rst       = 1'b1;
        req       = 4'b0001;
        a_in      = '0;
        b_in      = '0;
        cin_in    = '0;
        res_ready = 1'b1;
        tick();
        tick();
        #1;
        chk("rst_gnt", 32'(gnt), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_add_en", 32'(add_en), 32'(0));
        chk("rst_valid", 32'(res_valid), 32'(0));
        chk("rst_sum", 32'(res_sum), 32'(0));
        chk("rst_add_a", 32'(add_a), 32'(0));

        // Single request, no contention
        rst = 1'b0;
        set_op(0, 8'h3C, 8'h05, 1'b1);
        #1;
        chk("single_gnt", 32'(gnt), 32'(4'b0001));
        tick();
        req = 4'b0000;
        set_op(0, 8'h00, 8'h00, 1'b0);
        #1;
        chk("single_add_en", 32'(add_en), 32'(1));
        chk("single_add_a", 32'(add_a), 32'(8'h3C));
        chk("single_add_b", 32'(add_b), 32'(8'h05));
        chk("single_gnt_exec", 32'(gnt), 32'(0));
        chk("single_valid_exec", 32'(res_valid), 32'(0));
        tick();
        #1;
        chk("single_valid", 32'(res_valid), 32'(1));
        chk("single_sum", 32'(res_sum), 32'(8'h42));
        chk("single_cout", 32'(res_cout), 32'(0));
        chk("single_id", 32'(res_id), 32'(0));
        chk("single_add_en_hold", 32'(add_en), 32'(0));
        tick();
        #1;
        chk("single_idle_valid", 32'(res_valid), 32'(0));
        chk("single_idle_busy", 32'(busy), 32'(0));

        // Carry wrap on requester 3 (ptr 1 -> 3 is the only request)
        req = 4'b1000;
        set_op(3, 8'hFF, 8'h01, 1'b0);
        #1;
        chk("wrap_gnt", 32'(gnt), 32'(4'b1000));
        tick();
        req = 4'b0000;
        tick();
        #1;
        chk("wrap_sum", 32'(res_sum), 32'(8'h00));
        chk("wrap_cout", 32'(res_cout), 32'(1));
        chk("wrap_id", 32'(res_id), 32'(3));
        tick();

        // Round-robin fairness with all requests held
        for (int i = 0; i < 4; i++) set_op(i, fa[i], fb[i], fc[i]);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_gnt", 32'(gnt), 32'(1 << (k % 4)));
            tick();
            #1;
            chk("rr_add_en", 32'(add_en), 32'(1));
            chk("rr_gnt_exec", 32'(gnt), 32'(0));
            tick();
            #1;
            chk("rr_valid", 32'(res_valid), 32'(1));
            chk("rr_id", 32'(res_id), 32'(k % 4));
            chk("rr_sum", 32'(res_sum), 32'(fs[k % 4]));
            chk("rr_cout", 32'(res_cout), 32'(fo[k % 4]));
            chk("rr_gnt_hold", 32'(gnt), 32'(0));
            tick();
        end

        // Pointer rotation: lone grant to 2 leaves ptr 3, 0101 then wraps to 0
        req = 4'b0100;
        #1;
        chk("rot_gnt2", 32'(gnt), 32'(4'b0100));
        tick();
        req = 4'b0000;
        tick();
        tick();
        req = 4'b0101;
        #1;
        chk("rot_gnt0", 32'(gnt), 32'(4'b0001));

        // Backpressure: hold result 5 cycles with requester 1 pending
        tick();
        req       = 4'b0010;
        res_ready = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_valid", 32'(res_valid), 32'(1));
            chk("bp_id", 32'(res_id), 32'(0));
            chk("bp_sum", 32'(res_sum), 32'(8'h03));
            chk("bp_gnt", 32'(gnt), 32'(0));
            chk("bp_busy", 32'(busy), 32'(1));
            if (k == 4) res_ready = 1'b1;
            tick();
        end
        #1;
        chk("bp_release_gnt", 32'(gnt), 32'(4'b0010));
        tick();
        req = 4'b0000;
        tick();
        tick();

        // Reset during EXEC (ptr would otherwise make 1010 pick requester 3)
        req = 4'b0100;
        #1;
        chk("mid_gnt", 32'(gnt), 32'(4'b0100));
        tick();
        req = 4'b1010;
        #1;
        chk("mid_exec", 32'(add_en), 32'(1));
        rst = 1'b1;
        tick();
        #1;
        chk("mid_valid", 32'(res_valid), 32'(0));
        chk("mid_busy", 32'(busy), 32'(0));
        chk("mid_add_en", 32'(add_en), 32'(0));
        chk("mid_gnt_rst", 32'(gnt), 32'(0));
        rst = 1'b0;
        #1;
        chk("post_rst_gnt", 32'(gnt), 32'(4'b0010));
        tick();
        req = 4'b0000;
        tick();
        #1;
        chk("post_rst_id", 32'(res_id), 32'(1));
        tick();
        req = 4'b1000;
        #1;
        chk("post_rst_gnt3", 32'(gnt), 32'(4'b1000));
        tick();
        req = 4'b0000;
        tick();
        #1;
        chk("post_rst_id3", 32'(res_id), 32'(3));
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
